// File: rtl/up_counter_ctrl.sv
// up_counter_ctrl: up-counter with run-time terminal value,
// start/stop/clear/load control and saturating wrap count.
module up_counter_ctrl #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  limit,
  input  logic              one_shot,
  output logic [WIDTH-1:0]  counter,
  output logic              busy,
  output logic              done,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]  CNT_ONE  = 1;
  localparam logic [WIDTH-1:0]  CNT_ZERO = '0;
  localparam logic [WRAP_W-1:0] WRAP_ONE = 1;
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  counter_q, counter_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              at_lim;

  assign at_lim = (counter_q == limit);

  // Terminal strobe: only an enabled RUN cycle at limit
  // with no higher-priority request active.
  assign tc = reset & ~clear & ~load & ~stop & en
            & (state_q == RUN) & at_lim;

  // Next-state, count and wrap bookkeeping by priority.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    wrap_d    = wrap_q;
    if (clear) begin
      state_d   = IDLE;
      counter_d = CNT_ZERO;
      wrap_d    = '0;
    end else if (load) begin
      counter_d = load_val;
      if (state_q == DONE) state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = RUN;
        end
        RUN: begin
          if (stop) begin
            state_d = IDLE;
          end else if (en) begin
            if (at_lim) begin
              if (one_shot) begin
                state_d = DONE;
              end else begin
                counter_d = CNT_ZERO;
                if (wrap_q != WRAP_MAX)
                  wrap_d = wrap_q + WRAP_ONE;
              end
            end else begin
              counter_d = counter_q + CNT_ONE;
            end
          end
        end
        DONE: begin
          if (start) begin
            state_d   = RUN;
            counter_d = CNT_ZERO;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      counter_q <= '0;
      wrap_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      wrap_q    <= wrap_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign counter  = counter_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_up_counter_ctrl.sv
// tb_up_counter_ctrl: directed and random stimulus
// against a behavioural model of the counter.
module tb_up_counter_ctrl;

  localparam int W  = 4;
  localparam int WW = 2;
  localparam int CMAX = (1 << W);
  localparam int WMAX = (1 << WW) - 1;

  logic          clk = 1'b0;
  logic          reset, en, start, stop, clear, load;
  logic [W-1:0]  load_val, limit;
  logic          one_shot;
  logic [W-1:0]  counter;
  logic          busy, done, tc;
  logic [WW-1:0] wrap_cnt;

  int n_vec = 0;
  int n_err = 0;

  // model: 0 idle, 1 run, 2 done
  int m_st, m_cnt, m_wrap;

  up_counter_ctrl #(.WIDTH(W), .WRAP_W(WW)) dut (
    .clk(clk), .reset(reset), .en(en),
    .start(start), .stop(stop), .clear(clear),
    .load(load), .load_val(load_val),
    .limit(limit), .one_shot(one_shot),
    .counter(counter), .busy(busy), .done(done),
    .tc(tc), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_tc();
    return reset && !clear && !load && !stop && en
        && m_st == 1 && m_cnt == int'(limit);
  endfunction

  task automatic m_step();
    if (!reset) begin
      m_st = 0; m_cnt = 0; m_wrap = 0;
    end else if (clear) begin
      m_st = 0; m_cnt = 0; m_wrap = 0;
    end else if (load) begin
      m_cnt = int'(load_val);
      if (m_st == 2) m_st = 0;
    end else if (m_st == 1 && stop) begin
      m_st = 0;
    end else if (m_st == 0 && start) begin
      m_st = 1;
    end else if (m_st == 2 && start) begin
      m_st = 1; m_cnt = 0;
    end else if (m_st == 1 && en) begin
      if (m_cnt == int'(limit)) begin
        if (one_shot) m_st = 2;
        else begin
          m_cnt = 0;
          if (m_wrap < WMAX) m_wrap++;
        end
      end else begin
        m_cnt = (m_cnt + 1) % CMAX;
      end
    end
  endtask

  // Check current cycle, then advance one edge.
  task automatic tick();
    #1;
    chk("tc", tc, m_tc());
    chk("counter", counter, m_cnt);
    chk("busy", busy, m_st == 1);
    chk("done", done, m_st == 2);
    chk("wrap", wrap_cnt, m_wrap);
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic quiet();
    reset = 1; en = 0; start = 0; stop = 0;
    clear = 0; load = 0; load_val = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    quiet();
    reset = 0; start = 1; limit = 5; one_shot = 0;
    @(posedge clk);
    m_st = 0; m_cnt = 0; m_wrap = 0;
    @(negedge clk);
    // reset held with start asserted
    ticks(2);
    chk("rst_cnt", counter, 0);
    chk("rst_busy", busy, 0);
    quiet(); en = 1;
    ticks(5);
    chk("idle_cnt", counter, 0);
    // free-run wrap, limit 5
    start = 1; tick(); start = 0;
    ticks(13);
    chk("fr_wrap", wrap_cnt, 2);
    chk("fr_cnt", counter, 1);
    // one-shot, limit 3
    clear = 1; tick(); clear = 0;
    limit = 3; one_shot = 1;
    start = 1; tick(); start = 0;
    ticks(6);
    chk("os_cnt", counter, 3);
    chk("os_done", done, 1);
    chk("os_busy", busy, 0);
    start = 1; tick(); start = 0;
    chk("os_restart", counter, 0);
    chk("os_rbusy", busy, 1);
    ticks(2);
    // load above limit in RUN
    one_shot = 0; limit = 2;
    load = 1; load_val = 14; tick(); load = 0;
    ticks(6);
    // start+stop in RUN
    start = 1; stop = 1; tick();
    start = 0; stop = 0;
    chk("ss_busy", busy, 0);
    ticks(2);
    // clear beats load
    clear = 1; load = 1; load_val = 9; tick();
    clear = 0; load = 0;
    chk("cl_cnt", counter, 0);
    // en toggling in RUN
    limit = 9; start = 1; tick(); start = 0;
    for (int i = 0; i < 8; i++) begin
      en = i[0]; tick();
    end
    en = 1;
    while (m_cnt != 4) tick();
    reset = 0; tick(); reset = 1;
    chk("mr_cnt", counter, 0);
    chk("mr_busy", busy, 0);
    // wrap saturation, limit 0
    limit = 0; start = 1; tick(); start = 0;
    ticks(6);
    chk("sat_wrap", wrap_cnt, 3);
    // random phase
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(63) != 0);
      clear = ($urandom_range(31) == 0);
      load  = ($urandom_range(15) == 0);
      stop  = ($urandom_range(15) == 0);
      start = ($urandom_range(5) == 0);
      en    = ($urandom_range(3) != 0);
      load_val = W'($urandom);
      if ($urandom_range(19) == 0) limit = W'($urandom);
      if ($urandom_range(29) == 0) one_shot = ~one_shot;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/up_counter_ctrl.md
# up_counter_ctrl

Controllable up-counter with a programmable terminal value: the counting-up counterpart of the team's 4-bit down counter. It counts from 0 toward a run-time `limit`, then either wraps (free-run) or stops (one-shot). It sits in timer, sequencer and pacing paths that need a terminal-count strobe, start/stop control and wrap bookkeeping instead of a bare free-running decrement.

## Interface
Parameters:
- `WIDTH`, 4, counter and limit width (≥2).
- `WRAP_W`, 8, width of the saturating wrap counter.

Ports:
- `clk`  in  1  rising-edge clock; sole clock domain.
- `reset`  in  1  synchronous, active-low reset; sampled on `clk` rising edge, effective when 0.
- `en`  in  1  count enable; counting occurs only in RUN with `en`=1.
- `start`  in  1  IDLE/DONE → RUN request.
- `stop`  in  1  RUN → IDLE request; counter holds.
- `clear`  in  1  zero counter and wrap count; go to IDLE.
- `load`  in  1  synchronous parallel load of `load_val`.
- `load_val`  in  WIDTH  value for `load`.
- `limit`  in  WIDTH  terminal value; sampled every cycle (not latched).
- `one_shot`  in  1  1: stop at `limit` (DONE); 0: wrap to 0.
- `counter`  out  WIDTH  registered count.
- `busy`  out  1  registered; 1 iff state is RUN.
- `done`  out  1  registered; 1 iff state is DONE.
- `tc`  out  1  combinational terminal-count strobe.
- `wrap_cnt`  out  WRAP_W  registered count of wraps, saturating.

## Operation
- States: IDLE, RUN, DONE.
- Reset (`reset`=0): state IDLE, `counter`=0, `wrap_cnt`=0, `busy`=0, `done`=0. `tc`=0 follows.
- Per-cycle priority: reset > `clear` > `load` > `stop` > `start` > count.
- `clear`: `counter`←0, `wrap_cnt`←0, state←IDLE.
- `load`: `counter`←`load_val`.
  - From DONE → IDLE.
  - IDLE and RUN keep their state.
  - No counting occurs that cycle.
- IDLE: `counter` holds. `start`=1 → RUN; `counter` is unchanged on the transition.
- RUN, `en`=0: hold.
- RUN, `en`=1, `counter`≠`limit`: `counter`←`counter`+1 mod 2^WIDTH.
- RUN, `en`=1, `counter`=`limit`:
  - `one_shot`=1: `counter` holds at `limit`, state←DONE.
  - `one_shot`=0: `counter`←0; `wrap_cnt`←`wrap_cnt`+1, saturating at 2^WRAP_W−1.
- RUN, `stop`=1: state←IDLE, `counter` holds. `stop` beats `start` when both are asserted.
- DONE: `counter` holds. `start`=1 → RUN with `counter`←0.
- Ignored requests: `start` in RUN; `stop` in IDLE or DONE.
- `tc` = (state==RUN) & `en` & (`counter`==`limit`). It marks exactly the cycles that wrap or enter DONE, and is suppressed when `clear`, `load` or `stop` is active.
- `counter` > `limit` (via load or a `limit` change): counting continues upward, rolls 2^WIDTH−1→0 with no `tc` and no `wrap_cnt` change, then terminates at `limit`.
- `limit`=0: in free-run, `counter` stays 0, and `tc` and a wrap occur every enabled RUN cycle. In one-shot, the first enabled RUN cycle enters DONE.

## Timing
- All outputs except `tc` are registered and update on the `clk` rising edge after the causing input.
- `start` sampled at edge N: `busy`=1 after N. The first increment happens at edge N+1 if `en`=1.
- Period in free-run with `en` held high: `limit`+1 cycles per wrap; `tc` is one cycle wide.
- One-shot from 0: the enabled cycle with `counter`=`limit` asserts `tc`; `done`=1 after that edge. Total `limit`+1 enabled RUN cycles from start.
- `tc` is valid in the same cycle as its inputs; there is no registered delay.
- Reset mid-run takes effect at the next edge, overriding every other input.

## Test plan
- Reset/idle: hold `reset`=0 for 2 cycles with `start`=1 → `counter`=0, `busy`=0, `done`=0, `wrap_cnt`=0. Release with `en`=1 and no `start` for 5 cycles → `counter` stays 0.
- Free-run wrap: WIDTH=4, `limit`=5, `one_shot`=0, `start` pulse, `en`=1 for 13 cycles → sequence 0,1,2,3,4,5,0,1,…; `tc` high on each `counter`=5 cycle; `wrap_cnt`=2 after the second 5→0.
- One-shot: `limit`=3, `one_shot`=1, `start` → 0,1,2,3, then hold 3; `tc` one pulse; `done`=1, `busy`=0.
  - `start` again → `counter`=0, RUN.
- Load above limit: in RUN, `load`=1 with `load_val`=14 and `limit`=2 → 14,15,0,1,2; `tc` only at 2; no wrap counted on 15→0.
- Priorities: `start`+`stop` in RUN → IDLE.
  - `clear`+`load` → `counter`=0, IDLE.
  - `en` toggling 1/0 in RUN → counter advances only on `en`=1 cycles.
  - `reset`=0 mid-run at `counter`=4 → 0, IDLE next edge.
- Saturation: WRAP_W=2, `limit`=0, free-run for 6 enabled cycles → `wrap_cnt` goes 1,2,3,3,3,3; `tc` high all 6 cycles.
